// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the RAM data-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotating-priority find-first: the first set bit of req at or after ptr, wrapping.
module rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any                         = 1'b1;
                gnt[(int'(ptr) + i) % N]    = 1'b1;
                idx                         = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master arbiter for the single RAM data port, with lock, force override and
// read-data routing back to the issuing master.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int        N_MASTERS    = 2,
    parameter int        AW           = 32,
    parameter int        DW           = 32,
    parameter arb_mode_e MODE         = ARB_RR,
    parameter int        READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic [N_MASTERS-1:0]            i_req,
    input  logic [N_MASTERS-1:0]            i_lock,
    input  logic [N_MASTERS-1:0]            i_we,
    input  logic [N_MASTERS*(DW/8)-1:0]     i_be,
    input  logic [N_MASTERS*AW-1:0]         i_addr,
    input  logic [N_MASTERS*DW-1:0]         i_wdata,
    output logic [N_MASTERS-1:0]            o_gnt,
    output logic [N_MASTERS-1:0]            o_rvalid,
    output logic [DW-1:0]                   o_rdata,
    input  logic                            i_force_en,
    input  logic [$clog2(N_MASTERS)-1:0]    i_force_sel,
    output logic                            o_read_req,
    output logic [AW-1:0]                   o_read_addr,
    output logic                            o_write_enable,
    output logic [DW/8-1:0]                 o_byte_enable,
    output logic [AW-1:0]                   o_write_addr,
    output logic [DW-1:0]                   o_write_data,
    input  logic [DW-1:0]                   i_read_data
);

    localparam int BW = DW / 8;
    localparam int IW = $clog2(N_MASTERS);
    localparam int RL = READ_LATENCY;
    localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    // Handshake: master k holds i_req[k] and its bundle stable until it sees
    // o_gnt[k]=1 at an edge with clk_en=1; that edge is when the RAM access issues.
    logic                     owner_valid;
    logic [IW-1:0]            owner_idx;
    logic [IW-1:0]            ptr;
    logic [RL-1:0]            pipe_v;
    logic [RL-1:0][IW-1:0]    pipe_id;

    logic                     owner_hold;
    logic                     force_ok;
    logic [N_MASTERS-1:0]     eligible;
    logic [IW-1:0]            pick_ptr;
    logic [N_MASTERS-1:0]     pick_gnt;
    logic [IW-1:0]            pick_idx;
    logic                     pick_any;
    logic                     grant;
    logic                     issue_rd;
    logic                     issue_wr;

    always_comb begin
        force_ok   = int'(i_force_sel) < N_MASTERS;
        owner_hold = owner_valid && i_req[owner_idx];
        eligible   = i_req;
        if (i_force_en) begin
            eligible = force_ok ? (i_req & (ONE << i_force_sel)) : '0;
        end else if (owner_hold) begin
            eligible = ONE << owner_idx;
        end
        pick_ptr = (MODE == ARB_RR) ? ptr : '0;
    end

    rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req (eligible),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        grant          = pick_any && clk_en && rst_n;
        issue_rd       = grant && !i_we[pick_idx];
        issue_wr       = grant &&  i_we[pick_idx];
        o_gnt          = grant ? pick_gnt : '0;
        o_read_req     = 1'b0;
        o_read_addr    = '0;
        o_write_enable = 1'b0;
        o_byte_enable  = '0;
        o_write_addr   = '0;
        o_write_data   = '0;
        if (issue_rd) begin
            o_read_req  = 1'b1;
            o_read_addr = i_addr[int'(pick_idx)*AW +: AW];
        end
        if (issue_wr) begin
            o_write_enable = 1'b1;
            o_byte_enable  = i_be[int'(pick_idx)*BW +: BW];
            o_write_addr   = i_addr[int'(pick_idx)*AW +: AW];
            o_write_data   = i_wdata[int'(pick_idx)*DW +: DW];
        end
        o_rvalid = (clk_en && rst_n && pipe_v[RL-1]) ? (ONE << pipe_id[RL-1]) : '0;
        o_rdata  = i_read_data;
    end

    // Pointer stays frozen while a lock holder keeps the port and during force.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_valid <= 1'b0;
            owner_idx   <= '0;
            ptr         <= '0;
            pipe_v      <= '0;
            pipe_id     <= '0;
        end else if (clk_en) begin
            if (i_force_en) begin
                owner_valid <= 1'b0;
            end else if (grant) begin
                owner_valid <= i_lock[pick_idx];
                owner_idx   <= pick_idx;
            end else if (owner_valid && !i_req[owner_idx]) begin
                owner_valid <= 1'b0;
            end
            if (grant && !i_force_en && !owner_hold) begin
                ptr <= (int'(pick_idx) == N_MASTERS - 1) ? '0 : pick_idx + 1'b1;
            end
            pipe_v[0]  <= issue_rd;
            pipe_id[0] <= pick_idx;
            for (int i = 1; i < RL; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 2-master fixed-priority instance and a 5-master
// round-robin instance with two-cycle read latency.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int FN = 2;
    localparam int RN = 5;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [FN-1:0]    f_req, f_lock, f_we, f_gnt, f_rvalid;
    logic [FN*BW-1:0] f_be;
    logic [FN*AW-1:0] f_addr;
    logic [FN*DW-1:0] f_wdata;
    logic [DW-1:0]    f_rdata, f_write_data, f_read_data;
    logic             f_force_en, f_read_req, f_write_enable;
    logic [0:0]       f_force_sel;
    logic [AW-1:0]    f_read_addr, f_write_addr;
    logic [BW-1:0]    f_byte_enable;

    logic [RN-1:0]    r_req, r_lock, r_we, r_gnt, r_rvalid;
    logic [RN*BW-1:0] r_be;
    logic [RN*AW-1:0] r_addr;
    logic [RN*DW-1:0] r_wdata;
    logic [DW-1:0]    r_rdata, r_write_data, r_read_data;
    logic             r_force_en, r_read_req, r_write_enable;
    logic [2:0]       r_force_sel;
    logic [AW-1:0]    r_read_addr, r_write_addr;
    logic [BW-1:0]    r_byte_enable;

    mem_port_arbiter #(
        .N_MASTERS(FN), .AW(AW), .DW(DW), .MODE(ARB_FIXED), .READ_LATENCY(1)
    ) u_fix (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .i_req(f_req), .i_lock(f_lock), .i_we(f_we), .i_be(f_be),
        .i_addr(f_addr), .i_wdata(f_wdata), .o_gnt(f_gnt), .o_rvalid(f_rvalid),
        .o_rdata(f_rdata), .i_force_en(f_force_en), .i_force_sel(f_force_sel),
        .o_read_req(f_read_req), .o_read_addr(f_read_addr),
        .o_write_enable(f_write_enable), .o_byte_enable(f_byte_enable),
        .o_write_addr(f_write_addr), .o_write_data(f_write_data),
        .i_read_data(f_read_data)
    );

    mem_port_arbiter #(
        .N_MASTERS(RN), .AW(AW), .DW(DW), .MODE(ARB_RR), .READ_LATENCY(RL)
    ) u_rr (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .i_req(r_req), .i_lock(r_lock), .i_we(r_we), .i_be(r_be),
        .i_addr(r_addr), .i_wdata(r_wdata), .o_gnt(r_gnt), .o_rvalid(r_rvalid),
        .o_rdata(r_rdata), .i_force_en(r_force_en), .i_force_sel(r_force_sel),
        .o_read_req(r_read_req), .o_read_addr(r_read_addr),
        .o_write_enable(r_write_enable), .o_byte_enable(r_byte_enable),
        .o_write_addr(r_write_addr), .o_write_data(r_write_data),
        .i_read_data(r_read_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        f_req = '0; f_lock = '0; f_we = '0; f_be = '0; f_addr = '0; f_wdata = '0;
        f_force_en = 1'b0; f_force_sel = '0; f_read_data = '0;
        r_req = '0; r_lock = '0; r_we = '0; r_be = '0; r_addr = '0; r_wdata = '0;
        r_force_en = 1'b0; r_force_sel = '0; r_read_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        clk_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        clk_en = 1'b1;
        f_req = '1;
        r_req = '1;
        tick();
        settle();
        n_tests++;
        if ({f_gnt, f_rvalid, f_read_req, f_write_enable, f_read_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_fix gnt=%b rvalid=%b rd=%b wr=%b addr=%h expected all 0",
                     f_gnt, f_rvalid, f_read_req, f_write_enable, f_read_addr);
        end
        n_tests++;
        if ({r_gnt, r_rvalid, r_read_req, r_write_enable, r_read_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_rr gnt=%b rvalid=%b rd=%b wr=%b addr=%h expected all 0",
                     r_gnt, r_rvalid, r_read_req, r_write_enable, r_read_addr);
        end
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_starve();
        do_reset();
        f_req  = 2'b11;
        f_we   = 2'b00;
        f_addr = {32'h0000_0020, 32'h0000_0010};
        for (int i = 0; i < 6; i++) begin
            f_read_data = 32'h0000_A000 + 32'(i);
            settle();
            n_tests++;
            if (f_gnt !== 2'b01 || f_read_req !== 1'b1 || f_read_addr !== 32'h10) begin
                n_fail++;
                $display("FAIL fixed_gnt cyc=%0d gnt=%b rd=%b addr=%h expected 01/1/10",
                         i, f_gnt, f_read_req, f_read_addr);
            end
            n_tests++;
            if (f_rvalid !== ((i == 0) ? 2'b00 : 2'b01) || f_rdata !== 32'h0000_A000 + 32'(i)) begin
                n_fail++;
                $display("FAIL fixed_rvalid cyc=%0d rvalid=%b rdata=%h", i, f_rvalid, f_rdata);
            end
            tick();
        end
        f_req = 2'b10;
        f_we  = 2'b10;
        f_be  = 8'hC0;
        f_addr[63:32]  = 32'h44;
        f_wdata[63:32] = 32'h1234_5678;
        settle();
        n_tests++;
        if ({f_gnt, f_read_req, f_write_enable, f_byte_enable, f_write_addr, f_write_data, f_rvalid}
            !== {2'b10, 1'b0, 1'b1, 4'hC, 32'h44, 32'h1234_5678, 2'b01}) begin
            n_fail++;
            $display("FAIL fixed_write gnt=%b rd=%b wr=%b be=%h wa=%h wd=%h rvalid=%b expected 10/0/1/c/44/12345678/01",
                     f_gnt, f_read_req, f_write_enable, f_byte_enable, f_write_addr, f_write_data, f_rvalid);
        end
        tick();
        f_req = 2'b00;
        settle();
        n_tests++;
        if ({f_gnt, f_rvalid, f_read_req, f_write_enable, f_byte_enable, f_read_addr, f_write_addr, f_write_data} !== '0) begin
            n_fail++;
            $display("FAIL fixed_idle gnt=%b rvalid=%b wr=%b wa=%h wd=%h expected all 0",
                     f_gnt, f_rvalid, f_write_enable, f_write_addr, f_write_data);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rr_order();
        logic [RN-1:0] eg, ev;
        do_reset();
        r_req = '1;
        for (int m = 0; m < RN; m++) r_addr[m*AW +: AW] = 32'h1000 + 32'(m);
        for (int i = 0; i < 7; i++) begin
            eg = '0;
            eg[i % RN] = 1'b1;
            ev = '0;
            if (i >= RL) ev[(i - RL) % RN] = 1'b1;
            settle();
            n_tests++;
            if (r_gnt !== eg || r_read_addr !== 32'h1000 + 32'(i % RN)) begin
                n_fail++;
                $display("FAIL rr_order cyc=%0d gnt=%b addr=%h expected %b", i, r_gnt, r_read_addr, eg);
            end
            n_tests++;
            if (r_rvalid !== ev) begin
                n_fail++;
                $display("FAIL rr_rvalid cyc=%0d rvalid=%b expected %b", i, r_rvalid, ev);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [RN-1:0] reqs [5] = '{5'b00010, 5'b00011, 5'b00011, 5'b01001, 5'b00001};
        logic [RN-1:0] locks[5] = '{5'b00010, 5'b00010, 5'b00000, 5'b01000, 5'b00000};
        logic [RN-1:0] exps [5] = '{5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b00001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r_req  = reqs[i];
            r_lock = locks[i];
            settle();
            n_tests++;
            if (r_gnt !== exps[i]) begin
                n_fail++;
                $display("FAIL lock step=%0d gnt=%b expected %b", i, r_gnt, exps[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_latency();
        do_reset();
        r_req = 5'b00100;
        r_addr[2*AW +: AW] = 32'h100;
        r_addr[0 +: AW]    = 32'h200;
        settle();
        n_tests++;
        if (r_gnt !== 5'b00100 || r_read_req !== 1'b1 || r_read_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL lat_issue gnt=%b rd=%b addr=%h expected 00100/1/100", r_gnt, r_read_req, r_read_addr);
        end
        tick();
        r_req = '0;
        settle();
        n_tests++;
        if (r_rvalid !== 5'b0) begin
            n_fail++;
            $display("FAIL lat_early rvalid=%b expected 00000", r_rvalid);
        end
        tick();
        r_read_data = 32'hDEAD_BEEF;
        settle();
        n_tests++;
        if (r_rvalid !== 5'b00100 || r_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL lat_return rvalid=%b rdata=%h expected 00100/deadbeef", r_rvalid, r_rdata);
        end
        tick();
        r_read_data = '0;
        settle();
        n_tests++;
        if (r_rvalid !== 5'b0) begin
            n_fail++;
            $display("FAIL lat_single rvalid=%b expected 00000", r_rvalid);
        end
        tick();
        r_req = 5'b00100;
        tick();
        clk_en = 1'b0;
        r_req = 5'b00001;
        settle();
        n_tests++;
        if ({r_gnt, r_read_req, r_read_addr, r_rvalid} !== '0) begin
            n_fail++;
            $display("FAIL clken_off gnt=%b rd=%b addr=%h rvalid=%b expected all 0",
                     r_gnt, r_read_req, r_read_addr, r_rvalid);
        end
        tick();
        clk_en = 1'b1;
        settle();
        n_tests++;
        if (r_gnt !== 5'b00001 || r_read_addr !== 32'h200 || r_rvalid !== 5'b0) begin
            n_fail++;
            $display("FAIL clken_resume gnt=%b addr=%h rvalid=%b expected 00001/200/00000",
                     r_gnt, r_read_addr, r_rvalid);
        end
        tick();
        r_req = '0;
        settle();
        n_tests++;
        if (r_rvalid !== 5'b00100) begin
            n_fail++;
            $display("FAIL clken_delay rvalid=%b expected 00100", r_rvalid);
        end
        tick();
        settle();
        n_tests++;
        if (r_rvalid !== 5'b00001) begin
            n_fail++;
            $display("FAIL clken_order rvalid=%b expected 00001", r_rvalid);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_force();
        do_reset();
        r_req  = 5'b00001;
        r_lock = 5'b00001;
        tick();
        r_req = 5'b00011;
        r_lock = 5'b00011;
        r_force_en = 1'b1;
        r_force_sel = 3'd1;
        settle();
        n_tests++;
        if (r_gnt !== 5'b00010) begin
            n_fail++;
            $display("FAIL force_sel gnt=%b expected 00010", r_gnt);
        end
        tick();
        r_force_en = 1'b0;
        r_lock = '0;
        settle();
        n_tests++;
        if (r_gnt !== 5'b00010) begin
            n_fail++;
            $display("FAIL force_unlock gnt=%b expected 00010", r_gnt);
        end
        tick();
        r_req = '1;
        r_we = 5'b10101;
        r_force_en = 1'b1;
        for (int s = 5; s < 8; s++) begin
            r_force_sel = 3'(s);
            settle();
            n_tests++;
            if ({r_gnt, r_read_req, r_write_enable} !== '0) begin
                n_fail++;
                $display("FAIL force_range sel=%0d gnt=%b rd=%b wr=%b expected 0", s, r_gnt, r_read_req, r_write_enable);
            end
        end
        r_req = 5'b11011;
        r_force_sel = 3'd2;
        settle();
        n_tests++;
        if ({r_gnt, r_read_req, r_write_enable} !== '0) begin
            n_fail++;
            $display("FAIL force_idle gnt=%b rd=%b wr=%b expected 0", r_gnt, r_read_req, r_write_enable);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        r_req = 5'b00010;
        tick();
        r_req = '0;
        #2;
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (r_rvalid !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_hold rvalid=%b expected 00000", r_rvalid);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < RL + 2; i++) begin
            settle();
            n_tests++;
            if (r_rvalid !== 5'b0) begin
                n_fail++;
                $display("FAIL midrst_flush cyc=%0d rvalid=%b expected 00000", i, r_rvalid);
            end
            tick();
        end
        r_req = '1;
        settle();
        n_tests++;
        if (r_gnt !== 5'b00001) begin
            n_fail++;
            $display("FAIL midrst_ptr gnt=%b expected 00001", r_gnt);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        logic [RN-1:0] req, lk, we, exp_gnt, exp_rv;
        logic [AW-1:0] adr[RN];
        logic [DW-1:0] wd[RN];
        logic [BW-1:0] be[RN];
        logic [101:0]  exp_ram;
        logic [RN-1:0] exp_q[$];
        int            due_q[$];
        int ptr_m, owner, ecnt, g, fsel;
        bit en, fen;
        ptr_m = 0; owner = -1; ecnt = 0;
        req = '0; lk = '0; we = '0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < RN; m++) begin
                if (!req[m] && $urandom_range(0, 1) == 1) begin
                    req[m] = 1'b1;
                    lk[m]  = ($urandom_range(0, 3) == 0);
                    we[m]  = 1'($urandom_range(0, 1));
                    adr[m] = $urandom;
                    wd[m]  = $urandom;
                    be[m]  = 4'($urandom_range(1, 15));
                end
            end
            en   = ($urandom_range(0, 7) != 0);
            fen  = ($urandom_range(0, 9) == 0);
            fsel = $urandom_range(0, 7);
            clk_en = en;
            r_force_en = fen;
            r_force_sel = 3'(fsel);
            r_req = req; r_lock = lk; r_we = we;
            r_read_data = $urandom;
            for (int m = 0; m < RN; m++) begin
                r_addr[m*AW +: AW]  = adr[m];
                r_wdata[m*DW +: DW] = wd[m];
                r_be[m*BW +: BW]    = be[m];
            end
            g = -1;
            if (fen) begin
                if (fsel < RN && req[fsel]) g = fsel;
            end else if (owner >= 0 && req[owner]) begin
                g = owner;
            end else begin
                for (int k = 0; k < RN; k++) begin
                    if (g < 0 && req[(ptr_m + k) % RN]) g = (ptr_m + k) % RN;
                end
            end
            if (!en) g = -1;
            exp_gnt = '0;
            exp_ram = '0;
            if (g >= 0) begin
                exp_gnt[g] = 1'b1;
                if (we[g]) exp_ram = {1'b0, 1'b1, be[g], 32'h0, adr[g], wd[g]};
                else       exp_ram = {1'b1, 1'b0, 4'h0, adr[g], 32'h0, 32'h0};
            end
            exp_rv = '0;
            if (en && due_q.size() > 0 && due_q[0] == ecnt) exp_rv = exp_q[0];
            settle();
            n_tests++;
            if (r_gnt !== exp_gnt) begin
                n_fail++;
                $display("FAIL rnd_gnt cyc=%0d gnt=%b expected %b", cyc, r_gnt, exp_gnt);
            end
            n_tests++;
            if ({r_read_req, r_write_enable, r_byte_enable, r_read_addr, r_write_addr, r_write_data} !== exp_ram) begin
                n_fail++;
                $display("FAIL rnd_ram cyc=%0d got=%h expected %h", cyc,
                         {r_read_req, r_write_enable, r_byte_enable, r_read_addr, r_write_addr, r_write_data}, exp_ram);
            end
            n_tests++;
            if (r_rvalid !== exp_rv || r_rdata !== r_read_data) begin
                n_fail++;
                $display("FAIL rnd_rvalid cyc=%0d rvalid=%b expected %b", cyc, r_rvalid, exp_rv);
            end
            if (en) begin
                if (exp_rv != '0) begin
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end
                if (g >= 0 && !we[g]) begin
                    exp_q.push_back(exp_gnt);
                    due_q.push_back(ecnt + RL);
                end
                if (fen) begin
                    owner = -1;
                end else if (g >= 0) begin
                    if (owner != g) ptr_m = (g + 1) % RN;
                    owner = lk[g] ? g : -1;
                end else begin
                    owner = -1;
                end
                if (g >= 0) req[g] = 1'b0;
                ecnt++;
            end
            tick();
        end
        clk_en = 1'b1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fixed_starve();
        test_rr_order();
        test_lock();
        test_latency();
        test_force();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
